cpu_run_tracer: RTL and testbench
=================================

Name: cpu_run_tracer

Overview:
Synthesizable run controller and execution-trace buffer for the single-cycle MIPS core. It releases the CPU from reset and gates its execution for a configured number of retired instructions, or until a PC breakpoint is hit. Each retired instruction's PC, instruction, ALU result, write-back data and Zero flag are captured into a FIFO read through a valid/ready port. It replaces fixed-time, fixed-count simulation runs with a parametrised, hardware-resident controller.

Parameters:
PC_W, 5, width of the observed PC
DATA_W, 32, width of the instruction, ALU result and write-back data
DEPTH, 16, trace FIFO depth in records; power of two, at least 2
NUM_INSTR, 7, default instruction limit used when run_limit is 0
RST_CYCLES, 2, number of cycles cpu_reset_n is held low after start
STALL_ON_FULL, 1, 1 = stall the CPU while the FIFO is full; 0 = drop new records and flag overflow

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that begins a run
run_limit  in  16  instructions to retire; 0 selects NUM_INSTR; sampled on an accepted start
bp_en  in  1  enable the PC breakpoint; sampled on an accepted start
bp_pc  in  PC_W  breakpoint PC; sampled on an accepted start
pc_in  in  PC_W  CPU PC (PCOut)
instr_in  in  DATA_W  CPU current instruction
alu_result_in  in  DATA_W  CPU ALU result
wb_data_in  in  DATA_W  CPU register-file write data
zero_in  in  1  CPU ALU Zero flag
cpu_reset_n  out  1  CPU reset, active-low
cpu_run  out  1  CPU clock enable; one instruction retires per cycle while this is high
rd_valid  out  1  FIFO head record is valid
rd_ready  in  1  consumer accepts the head record
rd_pc  out  PC_W  head record: PC
rd_instr  out  DATA_W  head record: instruction
rd_alu  out  DATA_W  head record: ALU result
rd_wb  out  DATA_W  head record: write-back data
rd_zero  out  1  head record: Zero flag
busy  out  1  high in RESET_CPU and RUN
done  out  1  high in DONE
bp_hit  out  1  sticky: the run ended on the breakpoint
overflow  out  1  sticky: at least one record was dropped
retired_count  out  16  instructions retired in the current run

Behaviour:
- Reset (asynchronous, reset=0): FSM goes to IDLE. All outputs are 0: cpu_reset_n=0, cpu_run=0, rd_valid=0, busy=0, done=0, bp_hit=0, overflow=0, retired_count=0, rd_* data=0. The FIFO is emptied. Reset mid-run aborts the run immediately, with no further capture.
- States:
  - IDLE: cpu_reset_n=0.
  - RESET_CPU: cpu_reset_n=0 for exactly RST_CYCLES cycles, then go to RUN.
  - RUN: cpu_reset_n=1.
  - DONE: cpu_reset_n=1 and cpu_run=0, so CPU state is frozen for inspection. The FIFO remains readable.
- start: accepted only in IDLE or DONE. An accepted start:
  - latches limit = (run_limit==0 ? NUM_INSTR : run_limit), bp_en and bp_pc;
  - clears retired_count, bp_hit and overflow;
  - flushes the FIFO;
  - moves to RESET_CPU.
  start in RESET_CPU or RUN is ignored.
- cpu_run = (state==RUN) && !(STALL_ON_FULL && fifo_full). This is combinational from registered state only; it does not depend on rd_ready.
- Capture: on each rising edge with cpu_run=1, the values {pc_in, instr_in, alu_result_in, wb_data_in, zero_in} are pushed and retired_count increments. The pushed values are those presented during the cycle before the edge, i.e. the instruction that retires at that edge.
- Termination: evaluated on the capturing edge.
  - If retired_count+1 == limit, go to DONE.
  - If bp_en && pc_in==bp_pc, go to DONE and set bp_hit=1.
  - If both are true, go to DONE with bp_hit=1.
  - cpu_run is 0 from the next cycle onward.
- FIFO:
  - Show-ahead: rd_* reflect the head record whenever rd_valid=1.
  - A pop occurs when rd_valid && rd_ready.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a log2(DEPTH)+1-bit counter.
  - Push and pop in the same cycle leave occupancy unchanged, including when the FIFO is full.
  - In drop mode (STALL_ON_FULL=0), a push while full with no simultaneous pop discards the new record, sets overflow=1 and still increments retired_count.
  - A pop while empty has no effect.
- Stall mode: while full, cpu_run=0 and nothing is captured. After a pop, cpu_run returns to 1 on the following cycle.
- retired_count saturates at 16'hFFFF.

Test Plan:
1. Defaults, run_limit=0, rd_ready=1, pc_in increments 0,1,2…: start → cpu_reset_n low for 2 cycles; then cpu_run high for exactly 7 cycles; done=1, retired_count=7; 7 records read out in order with rd_pc=0..6.
2. Breakpoint: bp_en=1, bp_pc=3, run_limit=20 → DONE after the pc=3 capture; retired_count=4, bp_hit=1, cpu_run=0 thereafter.
3. Stall mode, DEPTH=4, rd_ready=0, run_limit=10 → cpu_run drops after 4 captures, rd_valid=1. Raising rd_ready → capture resumes; 10 records total in order, overflow=0.
4. Drop mode (STALL_ON_FULL=0), DEPTH=4, rd_ready=0, run_limit=6 → FIFO holds pc 0..3; overflow=1, retired_count=6, done=1.
5. Assert reset after 3 captures in RUN → all outputs 0 immediately, with no clock edge needed; a subsequent start runs a clean 7-instruction trace.
6. start pulsed during RUN → ignored, the run completes normally. start pulsed in DONE with 2 unread records → FIFO flushed (rd_valid=0), counters cleared, new run begins.

Source files
------------

// File: rtl/cpu_run_tracer.sv
// Run controller and execution-trace FIFO for the single-cycle MIPS core.
// Releases the CPU, gates it by instruction count or PC breakpoint, and records each retired instruction.
module cpu_run_tracer #(
   parameter int PC_W          = 5,
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 16,
   parameter int NUM_INSTR     = 7,
   parameter int RST_CYCLES    = 2,
   parameter int STALL_ON_FULL = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       run_limit,
   input  logic              bp_en,
   input  logic [PC_W-1:0]   bp_pc,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] wb_data_in,
   input  logic              zero_in,
   output logic              cpu_reset_n,
   output logic              cpu_run,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [PC_W-1:0]   rd_pc,
   output logic [DATA_W-1:0] rd_instr,
   output logic [DATA_W-1:0] rd_alu,
   output logic [DATA_W-1:0] rd_wb,
   output logic              rd_zero,
   output logic              busy,
   output logic              done,
   output logic              bp_hit,
   output logic              overflow,
   output logic [15:0]       retired_count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = PC_W + 3 * DATA_W + 1;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] RESET_CPU = 2'd1;
   localparam logic [1:0] RUN       = 2'd2;
   localparam logic [1:0] DONE      = 2'd3;

   logic [1:0]       state;
   logic [15:0]      rstCnt;
   logic [15:0]      limitQ;
   logic             bpEnQ;
   logic [PC_W-1:0]  bpPcQ;
   logic [15:0]      retiredCount;
   logic             bpHitQ;
   logic             overflowQ;

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [AW:0]      count;

   logic             fifoFull;
   logic             fifoEmpty;
   logic             startOk;
   logic             runActive;
   logic             pop;
   logic             pushOk;
   logic             limitHit;
   logic             bpMatch;
   logic [REC_W-1:0] wrRec;

   assign fifoFull  = (count == (AW+1)'(DEPTH));
   assign fifoEmpty = (count == '0);
   assign startOk   = start && ((state == IDLE) || (state == DONE));
   assign runActive = (state == RUN) && !((STALL_ON_FULL != 0) && fifoFull);
   assign pop       = !fifoEmpty && rd_ready;
   // In drop mode a capture while full only lands if the head leaves on the same edge.
   assign pushOk    = runActive && (!fifoFull || pop);
   assign limitHit  = (({1'b0, retiredCount} + 17'd1) == {1'b0, limitQ});
   assign bpMatch   = bpEnQ && (pc_in == bpPcQ);
   assign wrRec     = {pc_in, instr_in, alu_result_in, wb_data_in, zero_in};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         rstCnt       <= '0;
         limitQ       <= '0;
         bpEnQ        <= 1'b0;
         bpPcQ        <= '0;
         retiredCount <= '0;
         bpHitQ       <= 1'b0;
         overflowQ    <= 1'b0;
      end else if (startOk) begin
         limitQ       <= (run_limit == '0) ? 16'(NUM_INSTR) : run_limit;
         bpEnQ        <= bp_en;
         bpPcQ        <= bp_pc;
         retiredCount <= '0;
         bpHitQ       <= 1'b0;
         overflowQ    <= 1'b0;
         rstCnt       <= '0;
         state        <= RESET_CPU;
      end else begin
         case (state)
            RESET_CPU: begin
               if (rstCnt == 16'(RST_CYCLES - 1)) begin
                  state <= RUN;
               end else begin
                  rstCnt <= rstCnt + 16'd1;
               end
            end
            RUN: begin
               if (runActive) begin
                  if (retiredCount != 16'hFFFF) begin
                     retiredCount <= retiredCount + 16'd1;
                  end
                  if (fifoFull && !pop) begin
                     overflowQ <= 1'b1;
                  end
                  if (limitHit || bpMatch) begin
                     state <= DONE;
                  end
                  if (bpMatch) begin
                     bpHitQ <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (startOk) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushOk, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem[wrPtr] <= wrRec;
      end
   end

   assign rd_valid = !fifoEmpty;
   assign {rd_pc, rd_instr, rd_alu, rd_wb, rd_zero} = rd_valid ? mem[rdPtr] : '0;

   assign cpu_reset_n   = (state == RUN) || (state == DONE);
   assign cpu_run       = runActive;
   assign busy          = (state == RESET_CPU) || (state == RUN);
   assign done          = (state == DONE);
   assign bp_hit        = bpHitQ;
   assign overflow      = overflowQ;
   assign retired_count = retiredCount;

endmodule

// File: tb/tb_cpu_run_tracer.sv
// Bench for cpu_run_tracer: three configurations driven together and checked every cycle
// against a queue-based reference, plus literal expectations for the directed scenarios.
module tb_cpu_run_tracer;

   localparam int N    = 3;
   localparam int RSTC = 2;

   typedef struct packed {
      logic [4:0]  pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [31:0] wb;
      logic        zero;
   } rec_t;

   int depthK [N] = '{16, 4, 4};
   int stallK [N] = '{1, 0, 1};

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        start    = 1'b0;
   logic [15:0] runLimit = '0;
   logic        bpEn     = 1'b0;
   logic [4:0]  bpPc     = '0;
   logic [31:0] instrIn  = '0;
   logic [31:0] aluIn    = '0;
   logic [31:0] wbIn     = '0;
   logic        zeroIn   = 1'b0;
   logic [4:0]  pcIn     [N];
   logic        rdReady  [N];

   logic        cpuResetN    [N];
   logic        cpuRun       [N];
   logic        rdValid      [N];
   logic [4:0]  rdPc         [N];
   logic [31:0] rdInstr      [N];
   logic [31:0] rdAlu        [N];
   logic [31:0] rdWb         [N];
   logic        rdZero       [N];
   logic        busy         [N];
   logic        done         [N];
   logic        bpHit        [N];
   logic        overflow     [N];
   logic [15:0] retiredCount [N];

   initial forever #5 clk = ~clk;

   cpu_run_tracer #(.PC_W(5), .DATA_W(32), .DEPTH(16), .NUM_INSTR(7), .RST_CYCLES(2), .STALL_ON_FULL(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .run_limit(runLimit), .bp_en(bpEn), .bp_pc(bpPc),
      .pc_in(pcIn[0]), .instr_in(instrIn), .alu_result_in(aluIn), .wb_data_in(wbIn), .zero_in(zeroIn),
      .cpu_reset_n(cpuResetN[0]), .cpu_run(cpuRun[0]), .rd_valid(rdValid[0]), .rd_ready(rdReady[0]),
      .rd_pc(rdPc[0]), .rd_instr(rdInstr[0]), .rd_alu(rdAlu[0]), .rd_wb(rdWb[0]), .rd_zero(rdZero[0]),
      .busy(busy[0]), .done(done[0]), .bp_hit(bpHit[0]), .overflow(overflow[0]), .retired_count(retiredCount[0]));

   cpu_run_tracer #(.PC_W(5), .DATA_W(32), .DEPTH(4), .NUM_INSTR(7), .RST_CYCLES(2), .STALL_ON_FULL(0)) u1 (
      .clk(clk), .reset(reset), .start(start), .run_limit(runLimit), .bp_en(bpEn), .bp_pc(bpPc),
      .pc_in(pcIn[1]), .instr_in(instrIn), .alu_result_in(aluIn), .wb_data_in(wbIn), .zero_in(zeroIn),
      .cpu_reset_n(cpuResetN[1]), .cpu_run(cpuRun[1]), .rd_valid(rdValid[1]), .rd_ready(rdReady[1]),
      .rd_pc(rdPc[1]), .rd_instr(rdInstr[1]), .rd_alu(rdAlu[1]), .rd_wb(rdWb[1]), .rd_zero(rdZero[1]),
      .busy(busy[1]), .done(done[1]), .bp_hit(bpHit[1]), .overflow(overflow[1]), .retired_count(retiredCount[1]));

   cpu_run_tracer #(.PC_W(5), .DATA_W(32), .DEPTH(4), .NUM_INSTR(7), .RST_CYCLES(2), .STALL_ON_FULL(1)) u2 (
      .clk(clk), .reset(reset), .start(start), .run_limit(runLimit), .bp_en(bpEn), .bp_pc(bpPc),
      .pc_in(pcIn[2]), .instr_in(instrIn), .alu_result_in(aluIn), .wb_data_in(wbIn), .zero_in(zeroIn),
      .cpu_reset_n(cpuResetN[2]), .cpu_run(cpuRun[2]), .rd_valid(rdValid[2]), .rd_ready(rdReady[2]),
      .rd_pc(rdPc[2]), .rd_instr(rdInstr[2]), .rd_alu(rdAlu[2]), .rd_wb(rdWb[2]), .rd_zero(rdZero[2]),
      .busy(busy[2]), .done(done[2]), .bp_hit(bpHit[2]), .overflow(overflow[2]), .retired_count(retiredCount[2]));

   // Reference: phase 0 idle, 1 CPU held in reset, 2 running, 3 finished.
   int   mPhase [N];
   int   mRst   [N];
   int   mLimit [N];
   int   mRet   [N];
   int   mCap   [N];
   bit   mBpEn  [N];
   bit   mBpHit [N];
   bit   mOvf   [N];
   logic [4:0] mBpPc [N];
   rec_t mq [N][$];

   int nChecks = 0;
   int nErrors = 0;
   int got [$];

   function automatic bit mRunning(int k);
      return (mPhase[k] == 2) && !((stallK[k] != 0) && (mq[k].size() == depthK[k]));
   endfunction

   always @(posedge clk or negedge reset) begin
      bit   run, full, pop, hitL, hitB;
      rec_t r;
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
            mPhase[k] = 0; mRst[k] = 0; mLimit[k] = 0; mRet[k] = 0; mCap[k] = 0;
            mBpEn[k] = 0; mBpHit[k] = 0; mOvf[k] = 0; mBpPc[k] = '0;
            mq[k].delete();
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            run  = mRunning(k);
            full = (mq[k].size() == depthK[k]);
            pop  = (mq[k].size() != 0) && (rdReady[k] == 1'b1);
            if (start && (mPhase[k] == 0 || mPhase[k] == 3)) begin
               mLimit[k] = (runLimit == 16'd0) ? 7 : int'(runLimit);
               mBpEn[k]  = bpEn;
               mBpPc[k]  = bpPc;
               mRet[k] = 0; mCap[k] = 0; mBpHit[k] = 0; mOvf[k] = 0; mRst[k] = 0;
               mq[k].delete();
               mPhase[k] = 1;
            end else begin
               if (pop) void'(mq[k].pop_front());
               if (mPhase[k] == 1) begin
                  mRst[k]++;
                  if (mRst[k] == RSTC) mPhase[k] = 2;
               end else if (run) begin
                  r.pc = pcIn[k]; r.instr = instrIn; r.alu = aluIn; r.wb = wbIn; r.zero = zeroIn;
                  if (!full || pop) mq[k].push_back(r);
                  else mOvf[k] = 1;
                  hitL = (mRet[k] + 1 == mLimit[k]);
                  hitB = mBpEn[k] && (pcIn[k] == mBpPc[k]);
                  if (mRet[k] < 65535) mRet[k]++;
                  mCap[k]++;
                  if (hitL || hitB) mPhase[k] = 3;
                  if (hitB) mBpHit[k] = 1;
               end
            end
         end
      end
   end

   task automatic chk(int k, string nm, logic [63:0] act, logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL u%0d %s: got %0h expected %0h (t=%0t)", k, nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      rec_t h;
      #1;
      for (int k = 0; k < N; k++) begin
         h = (mq[k].size() != 0) ? mq[k][0] : '0;
         chk(k, "cpu_reset_n", 64'(cpuResetN[k]), 64'(mPhase[k] >= 2));
         chk(k, "cpu_run",     64'(cpuRun[k]),    64'(mRunning(k)));
         chk(k, "rd_valid",    64'(rdValid[k]),   64'(mq[k].size() != 0));
         chk(k, "rd_pc",       64'(rdPc[k]),      64'(h.pc));
         chk(k, "rd_instr",    64'(rdInstr[k]),   64'(h.instr));
         chk(k, "rd_alu",      64'(rdAlu[k]),     64'(h.alu));
         chk(k, "rd_wb",       64'(rdWb[k]),      64'(h.wb));
         chk(k, "rd_zero",     64'(rdZero[k]),    64'(h.zero));
         chk(k, "busy",        64'(busy[k]),      64'(mPhase[k] == 1 || mPhase[k] == 2));
         chk(k, "done",        64'(done[k]),      64'(mPhase[k] == 3));
         chk(k, "bp_hit",      64'(bpHit[k]),     64'(mBpHit[k]));
         chk(k, "overflow",    64'(overflow[k]),  64'(mOvf[k]));
         chk(k, "retired",     64'(retiredCount[k]), 64'(mRet[k]));
      end
   end

   // The emulated CPU's PC equals the number of instructions it has retired this run.
   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < N; k++) pcIn[k] = 5'(mCap[k]);
      instrIn = $urandom;
      aluIn   = $urandom;
      wbIn    = $urandom;
      zeroIn  = 1'($urandom_range(0, 1));
   endtask

   task automatic startRun(int lim, bit be, int bp);
      start    = 1'b1;
      runLimit = 16'(lim);
      bpEn     = be;
      bpPc     = 5'(bp);
      tick();
      start = 1'b0;
   endtask

   task automatic runWait(int k, int budget, bit collect, output int runCyc);
      got.delete();
      runCyc = 0;
      for (int c = 0; ; c++) begin
         if (cpuRun[k]) runCyc++;
         if (collect && rdValid[k] && rdReady[k]) got.push_back(int'(rdPc[k]));
         if (done[k]) break;
         if (c >= budget) begin
            nChecks++;
            nErrors++;
            $display("FAIL u%0d timeout: done still 0 after %0d cycles, required 1", k, budget);
            break;
         end
         tick();
      end
      for (int p = 0; p < 6; p++) begin
         tick();
         if (collect && rdValid[k] && rdReady[k]) got.push_back(int'(rdPc[k]));
      end
   endtask

   task automatic chkSeq(int k, string nm, int n);
      chk(k, {nm, "_count"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++) chk(k, {nm, "_pc"}, 64'(got[i]), 64'(i));
   endtask

   task automatic chkAllZero(string nm);
      for (int k = 0; k < N; k++) begin
         chk(k, nm, 64'(|{cpuResetN[k], cpuRun[k], rdValid[k], rdPc[k], rdInstr[k], rdAlu[k], rdWb[k],
                          rdZero[k], busy[k], done[k], bpHit[k], overflow[k], retiredCount[k]}), 64'd0);
      end
   endtask

   initial begin
      int rc;
      for (int k = 0; k < N; k++) begin
         pcIn[k]    = '0;
         rdReady[k] = 1'b1;
      end
      repeat (3) tick();
      chkAllZero("reset_outputs");
      reset = 1'b1;
      tick();

      // Default run: 2 reset cycles, 7 retired, records pc 0..6.
      startRun(0, 0, 0);
      chk(0, "t1_rstlow0", 64'(cpuResetN[0]), 64'd0);
      chk(0, "t1_busy", 64'(busy[0]), 64'd1);
      tick();
      chk(0, "t1_rstlow1", 64'(cpuResetN[0]), 64'd0);
      tick();
      chk(0, "t1_released", 64'(cpuResetN[0]), 64'd1);
      runWait(0, 100, 1, rc);
      chk(0, "t1_run_cycles", 64'(rc), 64'd7);
      chk(0, "t1_retired", 64'(retiredCount[0]), 64'd7);
      chk(0, "t1_done", 64'(done[0]), 64'd1);
      chkSeq(0, "t1", 7);

      // Breakpoint at pc 3 ends the run after 4 retirements.
      startRun(20, 1, 3);
      runWait(0, 100, 1, rc);
      chk(0, "t2_retired", 64'(retiredCount[0]), 64'd4);
      chk(0, "t2_bp_hit", 64'(bpHit[0]), 64'd1);
      chk(0, "t2_cpu_run", 64'(cpuRun[0]), 64'd0);
      chkSeq(0, "t2", 4);

      // Stall mode with a depth-4 FIFO and no consumer.
      rdReady[1] = 1'b0;
      rdReady[2] = 1'b0;
      startRun(10, 0, 0);
      repeat (6) tick();
      chk(2, "t3_stall_retired", 64'(retiredCount[2]), 64'd4);
      chk(2, "t3_stall_run", 64'(cpuRun[2]), 64'd0);
      chk(2, "t3_stall_valid", 64'(rdValid[2]), 64'd1);
      repeat (3) tick();
      chk(2, "t3_still_stalled", 64'(retiredCount[2]), 64'd4);
      rdReady[2] = 1'b1;
      runWait(2, 200, 1, rc);
      chkSeq(2, "t3", 10);
      chk(2, "t3_overflow", 64'(overflow[2]), 64'd0);
      chk(2, "t3_retired", 64'(retiredCount[2]), 64'd10);

      // Drop mode: records past the fourth are discarded.
      startRun(6, 0, 0);
      runWait(1, 100, 0, rc);
      chk(1, "t4_overflow", 64'(overflow[1]), 64'd1);
      chk(1, "t4_retired", 64'(retiredCount[1]), 64'd6);
      chk(1, "t4_done", 64'(done[1]), 64'd1);
      rdReady[1] = 1'b1;
      runWait(1, 10, 1, rc);
      chkSeq(1, "t4", 4);

      // Asynchronous reset mid-run, then a clean run.
      startRun(0, 0, 0);
      repeat (5) tick();
      chk(0, "t5_pre_reset_retired", 64'(retiredCount[0]), 64'd3);
      #3 reset = 1'b0;
      #1 chkAllZero("t5_async_reset");
      tick();
      reset = 1'b1;
      tick();
      startRun(0, 0, 0);
      runWait(0, 100, 1, rc);
      chkSeq(0, "t5", 7);
      chk(0, "t5_retired", 64'(retiredCount[0]), 64'd7);

      // start during RUN is ignored; start in DONE flushes unread records.
      startRun(0, 0, 0);
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      runWait(0, 100, 0, rc);
      chk(0, "t6_retired", 64'(retiredCount[0]), 64'd7);
      rdReady[0] = 1'b0;
      startRun(2, 0, 0);
      runWait(0, 100, 0, rc);
      chk(0, "t6_unread", 64'(rdValid[0]), 64'd1);
      startRun(0, 0, 0);
      chk(0, "t6_flushed", 64'(rdValid[0]), 64'd0);
      chk(0, "t6_cleared", 64'(retiredCount[0]), 64'd0);
      chk(0, "t6_busy", 64'(busy[0]), 64'd1);
      rdReady[0] = 1'b1;
      runWait(0, 100, 1, rc);
      chkSeq(0, "t6", 7);

      // Randomized traffic: consumer backpressure, start pulses, breakpoints, rare resets.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) rdReady[k] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            start    = 1'b1;
            runLimit = 16'($urandom_range(0, 12));
            bpEn     = 1'($urandom_range(0, 1));
            bpPc     = 5'($urandom_range(0, 15));
         end else begin
            start = 1'b0;
         end
         tick();
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b0;
            #2 reset = 1'b1;
         end
      end
      start = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
